// File: rtl/game_state_controller.sv
`default_nettype none
// ============================================================================
// Module   : game_state_controller
// Purpose  : Round sequencer for the VGA game. Handles idle, play,
//            post-hit invulnerability, pause and game over. Owns the lives
//            counter and a saturating 4-digit BCD score. Gates object
//            motion (run_en) and requests object repositioning (obj_reset).
// Revision : 1.0 - initial release
// ============================================================================
module game_state_controller #(
  parameter int INIT_LIVES   = 3,   // 1..7
  parameter int INVULN_TICKS = 64   // 1..255
) (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active-low
  input  logic        tick,
  input  logic        start,
  input  logic        hit,
  output logic [2:0]  state,
  output logic [2:0]  lives,
  output logic [15:0] score_bcd,
  output logic        run_en,
  output logic        invuln,
  output logic        obj_reset,
  output logic        game_over
);

  localparam logic [2:0] c_INIT_LIVES   = 3'(INIT_LIVES);
  localparam logic [7:0] c_INVULN_TICKS = 8'(INVULN_TICKS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_HIT   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Registered state
  state_t      state_q,     state_d;
  logic [2:0]  lives_q,     lives_d;
  logic [15:0] score_q,     score_d;
  logic [7:0]  cnt_q,       cnt_d;       // remaining invulnerability ticks
  logic        ret_hit_q,   ret_hit_d;   // pause returns to HIT (else PLAY)
  logic        obj_reset_q, obj_reset_d;
  logic        run_en_q,    invuln_q,    game_over_q;

  // Start button synchroniser and rising-edge detector
  logic s1_q, s2_q, s3_q;
  logic w_start_pulse;

  assign w_start_pulse = s2_q & ~s3_q;

  // BCD increment with per-digit carry; 9999 saturates instead of wrapping.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    bcd_inc = (v == 16'h9999) ? v : r;
  endfunction

  // Three-flop chain: two stages of metastability filtering plus edge history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= start;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Next-state, lives, score and invulnerability counter decisions.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    score_d     = score_q;
    cnt_d       = cnt_q;
    ret_hit_d   = ret_hit_q;
    obj_reset_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        lives_d = c_INIT_LIVES;
        score_d = 16'h0000;
        if (w_start_pulse) begin
          state_d     = ST_PLAY;
          obj_reset_d = 1'b1;
        end
      end

      ST_PLAY: begin
        if (tick) begin
          score_d = bcd_inc(score_q);
        end
        // A hit takes priority over a simultaneous pause request.
        if (hit) begin
          if (lives_q > 3'd1) begin
            lives_d     = lives_q - 3'd1;
            cnt_d       = c_INVULN_TICKS;
            obj_reset_d = 1'b1;
            state_d     = ST_HIT;
          end else begin
            lives_d = 3'd0;
            state_d = ST_OVER;
          end
        end else if (w_start_pulse) begin
          ret_hit_d = 1'b0;
          state_d   = ST_PAUSE;
        end
      end

      ST_HIT: begin
        // Hits are ignored while invulnerable.
        if (tick) begin
          score_d = bcd_inc(score_q);
          if (cnt_q == 8'd1) begin
            cnt_d   = 8'd0;
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        // The tick above still counts; if it expired the window, resume into PLAY.
        if (w_start_pulse) begin
          ret_hit_d = !(tick && (cnt_q == 8'd1));
          state_d   = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        if (w_start_pulse) begin
          state_d = ret_hit_q ? ST_HIT : ST_PLAY;
        end
      end

      ST_OVER: begin
        lives_d = 3'd0;
        if (w_start_pulse) begin
          state_d = ST_IDLE;
          lives_d = c_INIT_LIVES;
          score_d = 16'h0000;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        lives_d   = c_INIT_LIVES;
        score_d   = 16'h0000;
        cnt_d     = 8'd0;
        ret_hit_d = 1'b0;
      end
    endcase
  end

  // State register; flags are decoded from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      lives_q     <= c_INIT_LIVES;
      score_q     <= 16'h0000;
      cnt_q       <= 8'd0;
      ret_hit_q   <= 1'b0;
      obj_reset_q <= 1'b0;
      run_en_q    <= 1'b0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      cnt_q       <= cnt_d;
      ret_hit_q   <= ret_hit_d;
      obj_reset_q <= obj_reset_d;
      run_en_q    <= (state_d == ST_PLAY) || (state_d == ST_HIT);
      invuln_q    <= (state_d == ST_HIT) || ((state_d == ST_PAUSE) && ret_hit_d);
      game_over_q <= (state_d == ST_OVER);
    end
  end

  assign state     = state_q;
  assign lives     = lives_q;
  assign score_bcd = score_q;
  assign run_en    = run_en_q;
  assign invuln    = invuln_q;
  assign obj_reset = obj_reset_q;
  assign game_over = game_over_q;

endmodule
`default_nettype wire
